// File: rtl/ccip_txn_checker.sv
// Passive CCI-P transaction checker: per-tag read tracking, write/fence
// accounting, timeout scanning, AlmostFull policing and a prioritised
// single-cycle error stream with sticky and dropped-error bookkeeping.

package ccip_if_pkg;
  localparam logic [3:0] eREQ_RDLINE_I  = 4'h0;
  localparam logic [3:0] eREQ_RDLINE_S  = 4'h1;
  localparam logic [3:0] eREQ_WRLINE_I  = 4'h0;
  localparam logic [3:0] eREQ_WRLINE_M  = 4'h1;
  localparam logic [3:0] eREQ_WRPUSH_I  = 4'h2;
  localparam logic [3:0] eREQ_WRFENCE   = 4'h4;
  localparam logic [3:0] eREQ_INTR      = 4'h6;
  localparam logic [3:0] eRSP_RDLINE    = 4'h0;
  localparam logic [3:0] eRSP_UMSG      = 4'h4;
  localparam logic [3:0] eRSP_WRLINE    = 4'h0;
  localparam logic [3:0] eRSP_WRFENCE   = 4'h4;
  localparam logic [3:0] eRSP_INTR      = 4'h6;

  typedef struct packed {
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [15:0] mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [3:0] req_type;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    logic       format;
    logic [1:0] cl_num;
    logic [3:0] resp_type;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
  } t_if_ccip_Tx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;
endpackage

module ccip_txn_checker
  import ccip_if_pkg::*;
#(
  parameter int unsigned TAG_BITS       = 6,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned ALMFULL_SLACK  = 8,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 SoftReset,
  input  t_if_ccip_Rx          ccip_rx,
  input  t_if_ccip_Tx          ccip_tx,
  output logic [CNT_WIDTH-1:0] rd_outstanding,
  output logic [CNT_WIDTH-1:0] wr_outstanding,
  output logic [CNT_WIDTH-1:0] fence_outstanding,
  output logic                 err_valid,
  output logic [2:0]           err_code,
  output logic [15:0]          err_mdata,
  output logic [4:0]           err_sticky,
  output logic [15:0]          err_dropped
);

  localparam int unsigned DEPTH = 1 << TAG_BITS;

  typedef logic [TAG_BITS-1:0]  tag_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_DUP_TAG   = 3'd1,
    ERR_ORPHAN_RD = 3'd2,
    ERR_ORPHAN_WR = 3'd3,
    ERR_TIMEOUT   = 3'd4,
    ERR_ALMFULL   = 3'd5
  } err_e;

  // Net counter update, saturating at zero and at all-ones.
  function automatic cnt_t cnt_next(input cnt_t cnt, input logic [2:0] inc,
                                    input logic [2:0] dec);
    logic [CNT_WIDTH+2:0] sum;
    sum = {3'b000, cnt} + {{CNT_WIDTH{1'b0}}, inc};
    if (sum < {{CNT_WIDTH{1'b0}}, dec}) return '0;
    sum = sum - {{CNT_WIDTH{1'b0}}, dec};
    if (sum[CNT_WIDTH+2:CNT_WIDTH] != 3'b000) return '1;
    return sum[CNT_WIDTH-1:0];
  endfunction

  // True when the decrement exceeds what the counter (plus this cycle's increment) holds.
  function automatic logic cnt_under(input cnt_t cnt, input logic [2:0] inc,
                                     input logic [2:0] dec);
    logic [CNT_WIDTH+2:0] sum;
    sum = {3'b000, cnt} + {{CNT_WIDTH{1'b0}}, inc};
    return sum < {{CNT_WIDTH{1'b0}}, dec};
  endfunction

  // Tag table
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] rep_q;
  logic [2:0]       rem_q   [DEPTH];
  logic [31:0]      issue_q [DEPTH];

  // Scalar state
  logic [31:0] ts_q, ts_d;
  tag_t        scan_q, scan_d;
  logic [31:0] af0_cnt_q, af0_cnt_d;
  logic [31:0] af1_cnt_q, af1_cnt_d;
  cnt_t        rd_cnt_q, rd_cnt_d;
  cnt_t        wr_cnt_q, wr_cnt_d;
  cnt_t        fence_cnt_q, fence_cnt_d;
  logic        err_valid_q, err_valid_d;
  err_e        err_code_q, err_code_d;
  logic [15:0] err_mdata_q, err_mdata_d;
  logic [4:0]  sticky_q, sticky_d;
  logic [15:0] dropped_q, dropped_d;

  // Decoded bus activity
  logic       rd_req, rd_rsp, wr_req, fence_req, wr_rsp, fence_rsp;
  tag_t       req_tag, rsp_tag;
  logic [2:0] req_lines, wr_dec;
  logic       rsp_hit, rsp_frees, req_busy, req_alloc;
  logic [31:0] age;
  logic [4:0] ev;
  logic [2:0] n_ev, n_lost;
  logic [16:0] dropped_sum;

  // Decode requests/responses seen on the monitored buses this cycle.
  always_comb begin
    rd_req    = ccip_tx.c0.valid && (ccip_tx.c0.hdr.req_type == eREQ_RDLINE_I ||
                                     ccip_tx.c0.hdr.req_type == eREQ_RDLINE_S);
    req_tag   = ccip_tx.c0.hdr.mdata[TAG_BITS-1:0];
    req_lines = {1'b0, ccip_tx.c0.hdr.cl_len} + 3'd1;
    rd_rsp    = ccip_rx.c0.rspValid && (ccip_rx.c0.hdr.resp_type == eRSP_RDLINE);
    rsp_tag   = ccip_rx.c0.hdr.mdata[TAG_BITS-1:0];
    wr_req    = ccip_tx.c1.valid && (ccip_tx.c1.hdr.req_type == eREQ_WRLINE_I ||
                                     ccip_tx.c1.hdr.req_type == eREQ_WRLINE_M ||
                                     ccip_tx.c1.hdr.req_type == eREQ_WRPUSH_I);
    fence_req = ccip_tx.c1.valid && (ccip_tx.c1.hdr.req_type == eREQ_WRFENCE);
    wr_rsp    = ccip_rx.c1.rspValid && (ccip_rx.c1.hdr.resp_type == eRSP_WRLINE);
    fence_rsp = ccip_rx.c1.rspValid && (ccip_rx.c1.hdr.resp_type == eRSP_WRFENCE);
    wr_dec    = ccip_rx.c1.hdr.format ? ({1'b0, ccip_rx.c1.hdr.cl_num} + 3'd1) : 3'd1;
  end

  // Table lookups; the response is applied ahead of a same-cycle request.
  always_comb begin
    rsp_hit   = rd_rsp && busy_q[rsp_tag];
    rsp_frees = rsp_hit && (rem_q[rsp_tag] <= 3'd1);
    req_busy  = busy_q[req_tag] && !(rsp_frees && (rsp_tag == req_tag));
    req_alloc = rd_req && !req_busy;
    age       = ts_q - issue_q[scan_q];
  end

  // Raw error events, bit (code-1).
  always_comb begin
    ev    = '0;
    ev[0] = rd_req && req_busy;
    ev[1] = rd_rsp && !busy_q[rsp_tag];
    ev[2] = (wr_rsp && cnt_under(wr_cnt_q, {2'b00, wr_req}, wr_dec)) ||
            (fence_rsp && cnt_under(fence_cnt_q, {2'b00, fence_req}, wr_dec));
    ev[3] = busy_q[scan_q] && !rep_q[scan_q] && (age >= TIMEOUT_CYCLES);
    ev[4] = (ccip_tx.c0.valid && ccip_rx.c0TxAlmFull && (af0_cnt_q >= ALMFULL_SLACK)) ||
            (ccip_tx.c1.valid && ccip_rx.c1TxAlmFull && (af1_cnt_q >= ALMFULL_SLACK));
  end

  // Next-state for counters, timestamp, scan pointer and AlmFull run lengths.
  always_comb begin
    ts_d        = ts_q + 32'd1;
    scan_d      = scan_q + tag_t'(1);
    rd_cnt_d    = cnt_next(rd_cnt_q, rd_req ? req_lines : 3'd0, {2'b00, rd_rsp});
    wr_cnt_d    = cnt_next(wr_cnt_q, {2'b00, wr_req}, wr_rsp ? wr_dec : 3'd0);
    fence_cnt_d = cnt_next(fence_cnt_q, {2'b00, fence_req}, fence_rsp ? wr_dec : 3'd0);
    af0_cnt_d   = '0;
    af1_cnt_d   = '0;
    if (ccip_rx.c0TxAlmFull)
      af0_cnt_d = (af0_cnt_q < ALMFULL_SLACK) ? af0_cnt_q + 32'd1 : af0_cnt_q;
    if (ccip_rx.c1TxAlmFull)
      af1_cnt_d = (af1_cnt_q < ALMFULL_SLACK) ? af1_cnt_q + 32'd1 : af1_cnt_q;
  end

  // Priority arbitration of the error stream plus sticky/dropped bookkeeping.
  always_comb begin
    err_valid_d = |ev;
    err_code_d  = ERR_NONE;
    err_mdata_d = '0;
    if (ev[0]) begin
      err_code_d  = ERR_DUP_TAG;
      err_mdata_d = ccip_tx.c0.hdr.mdata;
    end else if (ev[1]) begin
      err_code_d  = ERR_ORPHAN_RD;
      err_mdata_d = ccip_rx.c0.hdr.mdata;
    end else if (ev[2]) begin
      err_code_d  = ERR_ORPHAN_WR;
    end else if (ev[3]) begin
      err_code_d  = ERR_TIMEOUT;
      err_mdata_d = 16'(scan_q);
    end else if (ev[4]) begin
      err_code_d  = ERR_ALMFULL;
    end
    n_ev        = {2'b00, ev[0]} + {2'b00, ev[1]} + {2'b00, ev[2]} +
                  {2'b00, ev[3]} + {2'b00, ev[4]};
    n_lost      = (n_ev != 3'd0) ? n_ev - 3'd1 : 3'd0;
    dropped_sum = {1'b0, dropped_q} + {14'b0, n_lost};
    dropped_d   = dropped_sum[16] ? '1 : dropped_sum[15:0];
    sticky_d    = sticky_q | ev;
  end

  // Scalar state registers.
  always_ff @(posedge clk) begin
    if (SoftReset) begin
      ts_q        <= '0;
      scan_q      <= '0;
      af0_cnt_q   <= '0;
      af1_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      fence_cnt_q <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_mdata_q <= '0;
      sticky_q    <= '0;
      dropped_q   <= '0;
    end else begin
      ts_q        <= ts_d;
      scan_q      <= scan_d;
      af0_cnt_q   <= af0_cnt_d;
      af1_cnt_q   <= af1_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      fence_cnt_q <= fence_cnt_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_mdata_q <= err_mdata_d;
      sticky_q    <= sticky_d;
      dropped_q   <= dropped_d;
    end
  end

  // Tag table update: scan mark, then response, then request (later writes win).
  // The issue stamp is the timestamp of the first cycle the entry is busy.
  always_ff @(posedge clk) begin
    if (SoftReset) begin
      busy_q <= '0;
      rep_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rem_q[i]   <= '0;
        issue_q[i] <= '0;
      end
    end else begin
      if (ev[3]) rep_q[scan_q] <= 1'b1;
      if (rsp_hit) begin
        rem_q[rsp_tag] <= rem_q[rsp_tag] - 3'd1;
        if (rsp_frees) busy_q[rsp_tag] <= 1'b0;
      end
      if (req_alloc) begin
        busy_q[req_tag]  <= 1'b1;
        rem_q[req_tag]   <= req_lines;
        issue_q[req_tag] <= ts_d;
        rep_q[req_tag]   <= 1'b0;
      end
    end
  end

  assign rd_outstanding    = rd_cnt_q;
  assign wr_outstanding    = wr_cnt_q;
  assign fence_outstanding = fence_cnt_q;
  assign err_valid         = err_valid_q;
  assign err_code          = err_code_q;
  assign err_mdata         = err_mdata_q;
  assign err_sticky        = sticky_q;
  assign err_dropped       = dropped_q;

endmodule

// File: tb/tb_ccip_txn_checker.sv
// Self-checking bench for ccip_txn_checker: directed scenarios followed by
// randomized traffic compared against a tag/counter reference model.
module tb_ccip_txn_checker;
  import ccip_if_pkg::*;

  localparam int TB = 4;
  localparam int TO = 100;
  localparam int SL = 8;
  localparam int CW = 16;
  localparam int MAXC = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              SoftReset;
  t_if_ccip_Rx       rx;
  t_if_ccip_Tx       tx;
  logic [CW-1:0]     rd_outstanding, wr_outstanding, fence_outstanding;
  logic              err_valid;
  logic [2:0]        err_code;
  logic [15:0]       err_mdata;
  logic [4:0]        err_sticky;
  logic [15:0]       err_dropped;

  ccip_txn_checker #(
    .TAG_BITS(TB), .TIMEOUT_CYCLES(TO), .ALMFULL_SLACK(SL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .SoftReset(SoftReset), .ccip_rx(rx), .ccip_tx(tx),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .fence_outstanding(fence_outstanding), .err_valid(err_valid),
    .err_code(err_code), .err_mdata(err_mdata), .err_sticky(err_sticky),
    .err_dropped(err_dropped)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_rem [16];
  int          m_rd, m_wr, m_fence, m_dropped;
  int          m_af_run [2];
  logic [4:0]  m_sticky;
  bit          e_valid;
  int          e_code;
  logic [15:0] e_mdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rx = '0;
    tx = '0;
  endtask

  task automatic rd_req(input int tag, input logic [1:0] cl_len, input logic [15:0] hi);
    tx.c0.valid         = 1'b1;
    tx.c0.hdr.req_type  = eREQ_RDLINE_S;
    tx.c0.hdr.cl_len    = cl_len;
    tx.c0.hdr.mdata     = hi | 16'(tag);
  endtask

  task automatic rd_rsp(input int tag);
    rx.c0.rspValid      = 1'b1;
    rx.c0.hdr.resp_type = eRSP_RDLINE;
    rx.c0.hdr.mdata     = 16'(tag);
  endtask

  function automatic int clampc(input int v);
    if (v < 0) return 0;
    if (v > MAXC) return MAXC;
    return v;
  endfunction

  // Advance one clock: update the model from the driven inputs, then compare.
  task automatic tick();
    bit [4:0]    evs;
    logic [15:0] md [5];
    int inc, dec, t, n;
    evs = '0;
    for (int i = 0; i < 5; i++) md[i] = '0;
    if (SoftReset) begin
      for (int i = 0; i < 16; i++) m_rem[i] = 0;
      m_rd = 0; m_wr = 0; m_fence = 0; m_dropped = 0;
      m_af_run[0] = 0; m_af_run[1] = 0;
      m_sticky = '0; e_valid = 0; e_code = 0; e_mdata = '0;
    end else begin
      inc = 0; dec = 0;
      if (rx.c0.rspValid && rx.c0.hdr.resp_type == eRSP_RDLINE) begin
        dec = 1;
        t = int'(rx.c0.hdr.mdata[TB-1:0]);
        if (m_rem[t] > 0) m_rem[t]--;
        else begin evs[1] = 1'b1; md[1] = rx.c0.hdr.mdata; end
      end
      if (tx.c0.valid && (tx.c0.hdr.req_type == eREQ_RDLINE_I ||
                          tx.c0.hdr.req_type == eREQ_RDLINE_S)) begin
        inc = (tx.c0.hdr.cl_len == 2'd3) ? 4 : int'(tx.c0.hdr.cl_len) + 1;
        t = int'(tx.c0.hdr.mdata[TB-1:0]);
        if (m_rem[t] > 0) begin evs[0] = 1'b1; md[0] = tx.c0.hdr.mdata; end
        else m_rem[t] = inc;
      end
      m_rd = clampc(m_rd + inc - dec);

      dec = rx.c1.hdr.format ? int'(rx.c1.hdr.cl_num) + 1 : 1;
      inc = (tx.c1.valid && tx.c1.hdr.req_type inside {eREQ_WRLINE_I, eREQ_WRLINE_M,
                                                       eREQ_WRPUSH_I}) ? 1 : 0;
      if (rx.c1.rspValid && rx.c1.hdr.resp_type == eRSP_WRLINE) begin
        if (m_wr + inc < dec) begin evs[2] = 1'b1; m_wr = 0; end
        else m_wr = clampc(m_wr + inc - dec);
      end else m_wr = clampc(m_wr + inc);
      inc = (tx.c1.valid && tx.c1.hdr.req_type == eREQ_WRFENCE) ? 1 : 0;
      if (rx.c1.rspValid && rx.c1.hdr.resp_type == eRSP_WRFENCE) begin
        if (m_fence + inc < dec) begin evs[2] = 1'b1; m_fence = 0; end
        else m_fence = clampc(m_fence + inc - dec);
      end else m_fence = clampc(m_fence + inc);

      if (tx.c0.valid && rx.c0TxAlmFull && m_af_run[0] >= SL) evs[4] = 1'b1;
      if (tx.c1.valid && rx.c1TxAlmFull && m_af_run[1] >= SL) evs[4] = 1'b1;
      m_af_run[0] = rx.c0TxAlmFull ? m_af_run[0] + 1 : 0;
      m_af_run[1] = rx.c1TxAlmFull ? m_af_run[1] + 1 : 0;

      m_sticky = m_sticky | evs;
      n = $countones(evs);
      e_valid = (n > 0);
      e_code = 0; e_mdata = '0;
      for (int i = 4; i >= 0; i--)
        if (evs[i]) begin e_code = i + 1; e_mdata = md[i]; end
      if (n > 0) m_dropped = clampc(m_dropped + n - 1);
    end
    @(posedge clk);
    #1;
    chk("rd_out", 32'(rd_outstanding), m_rd);
    chk("wr_out", 32'(wr_outstanding), m_wr);
    chk("fence_out", 32'(fence_outstanding), m_fence);
    chk("err_valid", 32'(err_valid), 32'(e_valid));
    chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
    chk("err_dropped", 32'(err_dropped), m_dropped);
    if (e_valid) begin
      chk("err_code", 32'(err_code), e_code);
      chk("err_mdata", 32'(err_mdata), 32'(e_mdata));
    end
  endtask

  task automatic do_reset();
    idle();
    SoftReset = 1'b1;
    tick();
    SoftReset = 1'b0;
  endtask

  initial begin
    int hits, hit_k, hit_code, hit_md, ch;
    bit af0, af1;
    SoftReset = 1'b1;
    idle();
    tick();
    tick();
    SoftReset = 1'b0;
    chk("reset_rd", 32'(rd_outstanding), 0);
    chk("reset_valid", 32'(err_valid), 0);
    chk("reset_code", 32'(err_code), 0);
    chk("reset_mdata", 32'(err_mdata), 0);
    chk("reset_sticky", 32'(err_sticky), 0);
    chk("reset_dropped", 32'(err_dropped), 0);

    // 4-line read on tag 5 drained by four responses
    rd_req(5, 2'd3, 16'h0); tick(); idle();
    chk("rd4_issue", 32'(rd_outstanding), 4);
    for (int i = 3; i >= 0; i--) begin
      rd_rsp(5); tick(); idle();
      chk("rd4_drain", 32'(rd_outstanding), i);
      chk("rd4_noerr", 32'(err_valid), 0);
    end

    // Duplicate tag 9
    do_reset();
    rd_req(9, 2'd0, 16'h0); tick(); idle();
    rd_req(9, 2'd0, 16'h0); tick(); idle();
    chk("dup_valid", 32'(err_valid), 1);
    chk("dup_code", 32'(err_code), 1);
    chk("dup_mdata", 32'(err_mdata), 9);
    chk("dup_rd", 32'(rd_outstanding), 2);

    // Orphan read response and orphan write response
    do_reset();
    rd_rsp(3); tick(); idle();
    chk("orph_rd_code", 32'(err_code), 2);
    chk("orph_rd_valid", 32'(err_valid), 1);
    tx.c1.valid = 1'b1; tx.c1.hdr.req_type = eREQ_WRLINE_I; tick(); idle();
    chk("wr_one", 32'(wr_outstanding), 1);
    rx.c1.rspValid = 1'b1; rx.c1.hdr.resp_type = eRSP_WRLINE;
    rx.c1.hdr.format = 1'b1; rx.c1.hdr.cl_num = 2'd1; tick(); idle();
    chk("orph_wr_code", 32'(err_code), 3);
    chk("orph_wr_mdata", 32'(err_mdata), 0);
    chk("orph_wr_cnt", 32'(wr_outstanding), 0);

    // Timeout on an unanswered read, then a late response
    do_reset();
    rd_req(7, 2'd0, 16'h0); tick(); idle();
    hits = 0; hit_k = -1; hit_code = 0; hit_md = 0;
    for (int k = 1; k <= 140; k++) begin
      @(posedge clk); #1;
      if (err_valid) begin
        hits++;
        hit_k = k; hit_code = int'(err_code); hit_md = int'(err_mdata);
      end
    end
    chk("to_count", hits, 1);
    chk("to_code", hit_code, 4);
    chk("to_mdata", hit_md, 7);
    chk("to_window", 32'((hit_k >= TO + 1) && (hit_k <= TO + (1 << TB) + 1)), 1);
    m_sticky = m_sticky | 5'b01000;
    rd_rsp(7); tick(); idle();
    chk("to_late_noerr", 32'(err_valid), 0);
    chk("to_late_rd", 32'(rd_outstanding), 0);

    // AlmostFull violation colliding with an orphan response
    do_reset();
    rx.c0TxAlmFull = 1'b1;
    for (int i = 0; i < SL; i++) tick();
    rd_req(2, 2'd0, 16'h0); rd_rsp(3); tick(); idle();
    chk("af_code", 32'(err_code), 2);
    chk("af_dropped", 32'(err_dropped), 1);
    chk("af_sticky", 32'(err_sticky), 32'h12);

    // Reset with reads in flight makes their responses orphans
    do_reset();
    for (int i = 1; i <= 3; i++) begin rd_req(i, 2'd0, 16'h0); tick(); idle(); end
    chk("rst3_rd", 32'(rd_outstanding), 3);
    do_reset();
    chk("rst3_zero", 32'(rd_outstanding), 0);
    chk("rst3_sticky", 32'(err_sticky), 0);
    for (int i = 1; i <= 3; i++) begin
      rd_rsp(i); tick(); idle();
      chk("rst3_orphan", 32'(err_code), 2);
      chk("rst3_mdata", 32'(err_mdata), i);
    end

    // Randomized traffic, short bursts after reset so no read can age out
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      af0 = 0; af1 = 0;
      for (int c = 0; c < 80; c++) begin
        idle();
        if ($urandom_range(0, 7) == 0) af0 = !af0;
        if ($urandom_range(0, 7) == 0) af1 = !af1;
        rx.c0TxAlmFull = af0;
        rx.c1TxAlmFull = af1;
        if ($urandom_range(0, 2) == 0) begin
          ch = $urandom_range(0, 2);
          rd_req($urandom_range(0, 15), (ch == 2) ? 2'd3 : 2'(ch),
                 16'($urandom_range(0, 4095)) << 4);
        end
        if ($urandom_range(0, 2) == 0) rd_rsp($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) begin
          ch = $urandom_range(0, 4);
          tx.c1.valid = 1'b1;
          tx.c1.hdr.req_type = (ch == 4) ? eREQ_INTR : (ch == 3) ? eREQ_WRFENCE : 4'(ch);
        end
        if ($urandom_range(0, 3) == 0) begin
          rx.c1.rspValid = 1'b1;
          rx.c1.hdr.resp_type = ($urandom_range(0, 2) == 0) ? eRSP_WRFENCE : eRSP_WRLINE;
          rx.c1.hdr.format = 1'($urandom_range(0, 1));
          rx.c1.hdr.cl_num = 2'($urandom_range(0, 3));
        end
        tick();
      end
      idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
